hp_sr_round: RTL and testbench



---
 rtl/hp_sr_round.sv | 233 +++++++++++++++++++++++
 tb/tb_hp_sr_round.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hp_sr_round.sv
// -----------------------------------------------------------------------------
// hp_sr_round
//   Stochastic-rounding stage placed directly after the half-precision
//   multiplier. It takes the multiplier's truncated packed result, the
//   extended mantissa (whose low num_round_bits bits are the discarded
//   fraction) and the one-hot result class. A pseudo-random value from an
//   internal 16-bit LFSR is added to the fraction. If that sum carries out,
//   the packed magnitude is incremented by one ULP. Zero, infinity and NaN
//   words pass through unchanged.
//
//   Two registered stages with a valid/ready handshake, full throughput:
//     stage 1 : capture the word and class, compute the round-up carry and
//               the inexact bit, step the LFSR.
//     stage 2 : apply the increment and reclassify (subnormal/normal/inf).
//
// Configuration macro:
//   SR_RNE_MODE_EN - adds input rnd_mode. With rnd_mode=1 the beat uses
//                    round-to-nearest-even instead of stochastic rounding.
//                    The LFSR steps on every transfer in both modes.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  upstream handshake
//   in_result          truncated packed result (num_bits)
//   in_round_mant      mantissa plus round bits (mant_width+num_round_bits)
//   in_zero..in_SNan   one-hot class of in_result
//   rnd_mode           (SR_RNE_MODE_EN only) 1 = round-to-nearest-even
//   out_valid/out_ready downstream handshake
//   out_result         rounded packed result
//   out_zero..out_SNan one-hot class after rounding
//   out_inexact        the discarded fraction was non-zero
// -----------------------------------------------------------------------------
module hp_sr_round #(
  parameter int          num_round_bits = 8,
  parameter int          num_bits       = 16,
  parameter int          exp_width      = 5,
  parameter int          mant_width     = 10,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [num_bits-1:0]                in_result,
  input  logic [mant_width+num_round_bits-1:0] in_round_mant,
  input  logic                               in_zero,
  input  logic                               in_inf,
  input  logic                               in_subN,
  input  logic                               in_Norm,
  input  logic                               in_QNan,
  input  logic                               in_SNan,
`ifdef SR_RNE_MODE_EN
  input  logic                               rnd_mode,
`endif
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [num_bits-1:0]                out_result,
  output logic                               out_zero,
  output logic                               out_inf,
  output logic                               out_subN,
  output logic                               out_Norm,
  output logic                               out_QNan,
  output logic                               out_SNan,
  output logic                               out_inexact
);

  typedef struct packed {
    logic zero;
    logic inf;
    logic subn;
    logic norm;
    logic qnan;
    logic snan;
  } cls_t;

  localparam logic [exp_width-1:0]      EXP_ONES  = {exp_width{1'b1}};
  localparam logic [exp_width-1:0]      EXP_ZERO  = '0;
  localparam logic [num_bits-2:0]       MAG_ONE   = {{(num_bits-2){1'b0}}, 1'b1};
`ifdef SR_RNE_MODE_EN
  localparam logic [num_round_bits-1:0] FRAC_HALF = {1'b1, {(num_round_bits-1){1'b0}}};
`endif

  // ---------------------------------------------------------------------------
  // Handshake: stage 1 can advance whenever stage 2 is empty or draining.
  // ---------------------------------------------------------------------------
  logic s1_valid;
  logic s1_advance;
  logic in_fire;

  assign s1_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s1_advance;
  assign in_fire    = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // LFSR: x^16+x^14+x^13+x^11+1, shifts left, feedback enters bit 0.
  // ---------------------------------------------------------------------------
  logic [15:0] lfsr;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // ---------------------------------------------------------------------------
  // Stage 1 combinational: round-up decision from the fraction.
  // ---------------------------------------------------------------------------
  logic [num_round_bits-1:0] frac;
  logic [num_round_bits-1:0] rnd;
  logic [num_round_bits-1:0] sum_unused;
  logic                      carry_sr;
  logic                      s1_carry_d;
  logic                      mant_unused;
  cls_t                      in_cls;

  assign frac   = in_round_mant[num_round_bits-1:0];
  assign rnd    = lfsr[num_round_bits-1:0];
  assign in_cls = '{zero: in_zero, inf: in_inf, subn: in_subN,
                    norm: in_Norm, qnan: in_QNan, snan: in_SNan};

  // Only the carry out of the extended-width sum matters.
  assign {carry_sr, sum_unused} = {1'b0, frac} + {1'b0, rnd};

  // The stored mantissa bits are already reflected in in_result.
  assign mant_unused = ^in_round_mant[mant_width+num_round_bits-1:num_round_bits];

`ifdef SR_RNE_MODE_EN
  logic carry_rne;
  assign carry_rne  = (frac > FRAC_HALF) || ((frac == FRAC_HALF) && in_result[0]);
  assign s1_carry_d = rnd_mode ? carry_rne : carry_sr;
`else
  assign s1_carry_d = carry_sr;
`endif

  // ---------------------------------------------------------------------------
  // Stage 1 registers.
  // ---------------------------------------------------------------------------
  logic [num_bits-1:0] s1_result;
  cls_t                s1_cls;
  logic                s1_carry;
  logic                s1_inexact;

  // NOTE: clocked state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the data registers are small, so they are reset along with the
  // control bits; this keeps out_* at a known 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr       <= LFSR_SEED;
      s1_valid   <= 1'b0;
      s1_result  <= '0;
      s1_cls     <= '0;
      s1_carry   <= 1'b0;
      s1_inexact <= 1'b0;
    end else begin
      if (in_fire) begin
        lfsr <= {lfsr[14:0], lfsr_fb};
      end
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_result  <= in_result;
          s1_cls     <= in_cls;
          s1_carry   <= s1_carry_d;
          s1_inexact <= (frac != '0);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 combinational: increment magnitude and reclassify.
  // The exponent carry is natural: a maximal subnormal becomes the smallest
  // normal, a normal mantissa overflow bumps the exponent.
  // ---------------------------------------------------------------------------
  logic [num_bits-2:0]  mag;
  logic [exp_width-1:0] mag_exp;
  logic [num_bits-1:0]  r2_result;
  cls_t                 r2_cls;
  logic                 r2_inexact;

  assign mag     = s1_result[num_bits-2:0] + MAG_ONE;
  assign mag_exp = mag[num_bits-2:mant_width];

  // NOTE: every output of this always_comb gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    r2_result  = s1_result;
    r2_cls     = s1_cls;
    r2_inexact = 1'b0;
    if (s1_cls.norm || s1_cls.subn) begin
      r2_inexact = s1_inexact;
      if (s1_carry) begin
        r2_result = {s1_result[num_bits-1], mag};
        r2_cls    = '0;
        if (mag_exp == EXP_ONES) begin
          r2_result[mant_width-1:0] = '0;
          r2_cls.inf                = 1'b1;
        end else if (mag_exp == EXP_ZERO) begin
          r2_cls.subn = 1'b1;
        end else begin
          r2_cls.norm = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 / output registers. Held while stalled so out_* stay stable.
  // ---------------------------------------------------------------------------
  cls_t out_cls;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_cls     <= '0;
      out_inexact <= 1'b0;
    end else if (s1_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result  <= r2_result;
        out_cls     <= r2_cls;
        out_inexact <= r2_inexact;
      end
    end
  end

  assign out_zero = out_cls.zero;
  assign out_inf  = out_cls.inf;
  assign out_subN = out_cls.subn;
  assign out_Norm = out_cls.norm;
  assign out_QNan = out_cls.qnan;
  assign out_SNan = out_cls.snan;

endmodule

// File: tb/tb_hp_sr_round.sv
// -----------------------------------------------------------------------------
// tb_hp_sr_round
//   Self-checking bench for hp_sr_round (default build, stochastic rounding).
//   A behavioural model computes each expected beat with integer arithmetic
//   from the rounding rules and queues it at the input transfer. One monitor
//   on the falling edge pops and compares every output transfer, checks
//   stall stability, and checks the cycle after reset. Directed beats pin
//   known literal results.
// -----------------------------------------------------------------------------
module tb_hp_sr_round;

  localparam logic [5:0] CLS_ZERO = 6'b100000;
  localparam logic [5:0] CLS_INF  = 6'b010000;
  localparam logic [5:0] CLS_SUBN = 6'b001000;
  localparam logic [5:0] CLS_NORM = 6'b000100;
  localparam logic [5:0] CLS_QNAN = 6'b000010;
  localparam logic [5:0] CLS_SNAN = 6'b000001;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic [17:0] in_round_mant;
  logic [5:0]  in_cls;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_zero, out_inf, out_subN, out_Norm, out_QNan, out_SNan;
  logic        out_inexact;
  logic [5:0]  out_cls;

  assign out_cls = {out_zero, out_inf, out_subN, out_Norm, out_QNan, out_SNan};

  hp_sr_round dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_result     (in_result),
    .in_round_mant (in_round_mant),
    .in_zero       (in_cls[5]),
    .in_inf        (in_cls[4]),
    .in_subN       (in_cls[3]),
    .in_Norm       (in_cls[2]),
    .in_QNan       (in_cls[1]),
    .in_SNan       (in_cls[0]),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_zero      (out_zero),
    .out_inf       (out_inf),
    .out_subN      (out_subN),
    .out_Norm      (out_Norm),
    .out_QNan      (out_QNan),
    .out_SNan      (out_SNan),
    .out_inexact   (out_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [15:0] res;
    logic [5:0]  cls;
    logic        inexact;
    int          cyc;
  } exp_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic exp_t model(input logic [15:0] r, input logic [7:0] frac,
                                 input logic [5:0] c, input logic [15:0] st);
    exp_t e;
    int   mag;
    int   ex;
    e.res     = r;
    e.cls     = c;
    e.inexact = 1'b0;
    e.cyc     = 0;
    if (c == CLS_NORM || c == CLS_SUBN) begin
      e.inexact = (frac != 8'd0);
      if (int'(frac) + int'(st[7:0]) >= 256) begin
        mag = int'(r[14:0]) + 1;
        ex  = mag / 1024;
        if (ex == 31) begin
          e.res = {r[15], 15'h7C00};
          e.cls = CLS_INF;
        end else begin
          e.res = {r[15], 15'(mag)};
          e.cls = (ex == 0) ? CLS_SUBN : CLS_NORM;
        end
      end
    end
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor / compare process (falling edge: inputs and outputs are settled,
  // and what is seen here is what the next rising edge will transfer).
  // ---------------------------------------------------------------------------
  exp_t        q[$];
  logic [15:0] m_lfsr    = 16'hACE1;
  int          cyc       = 0;
  bit          post_rst  = 1'b0;
  bit          hold_v    = 1'b0;
  logic [15:0] hold_res;
  logic [5:0]  hold_cls;
  logic        hold_inx;
  bit          lat_mode  = 1'b0;
  bit          stat_mode = 1'b0;
  int          ones_cnt  = 0;
  int          stat_outs = 0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      q.delete();
      m_lfsr   = 16'hACE1;
      hold_v   = 1'b0;
      post_rst = 1'b1;
    end else begin
      if (post_rst) begin
        check("out_valid_after_rst", {31'd0, out_valid}, 32'd0);
        post_rst = 1'b0;
      end
      if (hold_v) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_result", {16'd0, out_result}, {16'd0, hold_res});
        check("stall_flags", {26'd0, out_cls, out_inexact} , {26'd0, hold_cls, hold_inx});
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output: got %0h expected no beat", out_result);
        end else begin
          e = q.pop_front();
          check("out_result", {16'd0, out_result}, {16'd0, e.res});
          check("out_class", {26'd0, out_cls}, {26'd0, e.cls});
          check("out_inexact", {31'd0, out_inexact}, {31'd0, e.inexact});
          if (lat_mode) check("latency", cyc - e.cyc, 32'd2);
          if (stat_mode) begin
            stat_outs++;
            if (out_result == 16'h3C01) ones_cnt++;
          end
        end
      end
      hold_v   = out_valid && !out_ready;
      hold_res = out_result;
      hold_cls = out_cls;
      hold_inx = out_inexact;
      if (in_valid && in_ready) begin
        e     = model(in_result, in_round_mant[7:0], in_cls, m_lfsr);
        e.cyc = cyc;
        q.push_back(e);
        m_lfsr = lfsr_next(m_lfsr);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge).
  // ---------------------------------------------------------------------------
  task automatic send(input logic [15:0] r, input logic [7:0] frac, input logic [5:0] c);
    bit ok;
    in_valid      = 1'b1;
    in_result     = r;
    in_round_mant = {r[9:0], frac};
    in_cls        = c;
    ok            = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready stayed 0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = out_valid;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: out_valid stayed 0 expected 1", name);
    end
  endtask

  task automatic rand_beat();
    logic [15:0] r;
    logic [5:0]  c;
    logic [9:0]  m;
    logic [4:0]  ex;
    m  = ($urandom_range(0, 2) == 0) ? 10'h3FF : 10'($urandom);
    ex = ($urandom_range(0, 3) == 0) ? 5'd30 : 5'($urandom_range(1, 30));
    case ($urandom_range(0, 7))
      0: begin r = {1'($urandom), 15'h0000}; c = CLS_ZERO; end
      1: begin r = {1'($urandom), 15'h7C00}; c = CLS_INF; end
      2: begin r = {1'($urandom), 5'd31, 1'b1, 9'($urandom)}; c = CLS_QNAN; end
      3: begin r = {1'($urandom), 5'd31, 1'b0, 9'($urandom_range(1, 511))}; c = CLS_SNAN; end
      4, 5: begin r = {1'($urandom), 5'd0, (m == 10'd0) ? 10'd1 : m}; c = CLS_SUBN; end
      default: begin r = {1'($urandom), ex, m}; c = CLS_NORM; end
    endcase
    in_result     = r;
    in_round_mant = {r[9:0], 8'($urandom)};
    in_cls        = c;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence.
  // ---------------------------------------------------------------------------
  initial begin
    rst           = 1'b1;
    in_valid      = 1'b0;
    in_result     = '0;
    in_round_mant = '0;
    in_cls        = '0;
    out_ready     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_result", {16'd0, out_result}, 32'd0);
    check("rst_out_flags", {26'd0, out_cls, out_inexact}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    lat_mode = 1'b1;

    // Exact value, no rounding.
    send(16'h3C00, 8'h00, CLS_NORM);
    wait_out("t1");
    check("t1_result", {16'd0, out_result}, 32'h3C00);
    check("t1_class", {26'd0, out_cls}, {26'd0, CLS_NORM});
    check("t1_inexact", {31'd0, out_inexact}, 32'd0);

    // Largest normal rounds up to infinity (rnd = 8'hC3).
    send(16'h7BFF, 8'hFF, CLS_NORM);
    wait_out("t2");
    check("t2_result", {16'd0, out_result}, 32'h7C00);
    check("t2_class", {26'd0, out_cls}, {26'd0, CLS_INF});
    check("t2_inexact", {31'd0, out_inexact}, 32'd1);

    // Largest subnormal becomes smallest normal, both signs.
    send(16'h03FF, 8'hFF, CLS_SUBN);
    wait_out("t3");
    check("t3_result", {16'd0, out_result}, 32'h0400);
    check("t3_class", {26'd0, out_cls}, {26'd0, CLS_NORM});
    send(16'h83FF, 8'hFF, CLS_SUBN);
    wait_out("t4");
    check("t4_result", {16'd0, out_result}, 32'h8400);
    check("t4_class", {26'd0, out_cls}, {26'd0, CLS_NORM});

    // NaN passes through; the following beat proves the LFSR stepped.
    send(16'h7E00, 8'hFF, CLS_QNAN);
    wait_out("t5");
    check("t5_result", {16'd0, out_result}, 32'h7E00);
    check("t5_class", {26'd0, out_cls}, {26'd0, CLS_QNAN});
    check("t5_inexact", {31'd0, out_inexact}, 32'd0);
    send(16'h3C00, 8'h40, CLS_NORM);
    repeat (4) @(posedge clk);
    #1;

    // Statistical run: frac = half rounds up about half the time.
    stat_mode = 1'b1;
    for (int i = 0; i < 4096; i++) send(16'h3C00, 8'h80, CLS_NORM);
    repeat (6) @(posedge clk);
    #1;
    stat_mode = 1'b0;
    check("stat_beats", stat_outs, 32'd4096);
    check("stat_half_in_range", {31'd0, (ones_cnt >= 1898 && ones_cnt <= 2198)}, 32'd1);
    lat_mode = 1'b0;

    // Random traffic with back-pressure and a mid-stream reset.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 1) == 1);
      rst       = (i == 700 || i == 701);
      rand_beat();
    end

    // Drain: nothing must be left behind.
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("drain_queue_empty", q.size(), 32'd0);
    check("drain_out_valid", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time %0t expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
